two_64bit_demux: RTL and testbench

TWO_64BIT_DEMUX -- requirements
Module: two_64bit_demux

---
 rtl/two_64bit_demux.sv | 94 +++++++++
 tb/tb_two_64bit_demux.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/two_64bit_demux.sv
// 1-to-4 demultiplexer feeding four independent DEPTH-entry FIFOs, one per lane,
// with a free-running 16-bit count of accepted input words.
`timescale 1ns/1ps

module two_64bit_demux #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       dest,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [15:0]      xfer_count
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [4][DEPTH];
    logic [PW-1:0]    rd_ptr [4];
    logic [PW-1:0]    wr_ptr [4];
    logic [CW-1:0]    count [4];
    logic [CW-1:0]    count_nxt [4];
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [WIDTH-1:0] head [4];

    // A full lane refuses input even while it is being drained this cycle.
    always_comb begin
        in_ready = (count[dest] != FULL);
        for (int i = 0; i < 4; i++) begin
            push[i] = in_valid && in_ready && (dest == 2'(i));
            pop[i]  = out_valid[i] && out_ready[i];
            head[i] = out_valid[i] ? mem[i][rd_ptr[i]] : '0;
            count_nxt[i] = count[i];
            if (push[i] && !pop[i]) begin
                count_nxt[i] = count[i] + CW'(1);
            end else if (!push[i] && pop[i]) begin
                count_nxt[i] = count[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            out_valid  <= 4'b0000;
            xfer_count <= 16'h0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                count[i]     <= count_nxt[i];
                out_valid[i] <= (count_nxt[i] != '0);
            end
            if (in_valid && in_ready) begin
                xfer_count <= xfer_count + 16'h0001;
            end
        end
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule

// File: tb/tb_two_64bit_demux.sv
// Scoreboard bench for two_64bit_demux: stimulus pushes expected words into per-lane
// queues, a negedge monitor compares DUT outputs against them and pops on handshakes.
`timescale 1ns/1ps

module tb_two_64bit_demux;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       dest = 2'd0;
    logic [WIDTH-1:0] in_data = '0;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = 4'b0000;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [15:0]      xfer_count;

    logic [WIDTH-1:0] exp_q [4][$];
    logic [15:0]      model_xfer = 16'h0000;
    logic             checking = 1'b0;
    logic             last_ready;
    int               compared = 0;
    int               mismatched = 0;
    logic [WIDTH-1:0] out_data_arr [4];

    two_64bit_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dest(dest), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    assign out_data_arr[0] = out_data0;
    assign out_data_arr[1] = out_data1;
    assign out_data_arr[2] = out_data2;
    assign out_data_arr[3] = out_data3;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, snapshots in_ready, and applies the reference
    // model's view of the edge (lane not full -> word joins that lane's queue).
    task automatic applyStimulus(input logic v, input logic [1:0] d,
                                 input logic [WIDTH-1:0] data, input logic [3:0] ordy,
                                 input logic rst);
        logic accept;
        reset     = rst;
        in_valid  = v;
        dest      = d;
        in_data   = data;
        out_ready = ordy;
        accept = v && !rst && (exp_q[d].size() < DEPTH);
        #2;
        last_ready = in_ready;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) exp_q[i].delete();
            model_xfer = 16'h0000;
        end else if (accept) begin
            exp_q[d].push_back(data);
            model_xfer = model_xfer + 16'h0001;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("in_ready", {63'b0, in_ready},
                        {63'b0, (exp_q[dest].size() < DEPTH)});
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("out_valid[%0d]", i), {63'b0, out_valid[i]},
                            {63'b0, (exp_q[i].size() != 0)});
                checkOutput($sformatf("out_data%0d", i), out_data_arr[i],
                            (exp_q[i].size() != 0) ? exp_q[i][0] : '0);
            end
            checkOutput("xfer_count", {48'b0, xfer_count}, {48'b0, model_xfer});
            if (!reset) begin
                for (int i = 0; i < 4; i++) begin
                    if (out_ready[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        checking = 1'b1;

        // Single push to lane 2, consumer stalled
        applyStimulus(1'b1, 2'd2, 64'hA5A5_0000_0000_0001, 4'b0000, 1'b0);
        checkOutput("d1_out_valid", {60'b0, out_valid}, 64'h4);
        checkOutput("d1_out_data2", out_data2, 64'hA5A5_0000_0000_0001);
        checkOutput("d1_xfer", {48'b0, xfer_count}, 64'h1);

        // Lane 0 fills after two words, third held until space frees
        applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        applyStimulus(1'b1, 2'd0, 64'd1, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd0, 64'd2, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd0, 64'd3, 4'b0000, 1'b0);
        checkOutput("d2_full_ready", {63'b0, last_ready}, 64'h0);
        applyStimulus(1'b1, 2'd0, 64'd3, 4'b0001, 1'b0);
        checkOutput("d2_full_pop_ready", {63'b0, last_ready}, 64'h0);
        checkOutput("d2_head_after_pop1", out_data0, 64'd2);
        applyStimulus(1'b1, 2'd0, 64'd3, 4'b0001, 1'b0);
        checkOutput("d2_ready_after_space", {63'b0, last_ready}, 64'h1);
        checkOutput("d2_head_after_pop2", out_data0, 64'd3);
        applyStimulus(1'b0, 2'd0, '0, 4'b0001, 1'b0);
        checkOutput("d2_drained_valid", {63'b0, out_valid[0]}, 64'h0);
        checkOutput("d2_drained_data", out_data0, 64'h0);

        // Lane 1 full and stalled does not block lane 3
        applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        applyStimulus(1'b1, 2'd1, 64'hAA, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd1, 64'hBB, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd3, 64'h55, 4'b0000, 1'b0);
        checkOutput("d3_lane3_ready", {63'b0, last_ready}, 64'h1);
        checkOutput("d3_out_valid", {60'b0, out_valid}, 64'hA);
        checkOutput("d3_lane1_head", out_data1, 64'hAA);
        checkOutput("d3_lane3_head", out_data3, 64'h55);

        // Simultaneous push and pop on a lane holding one word
        applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        applyStimulus(1'b1, 2'd0, 64'h11, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd0, 64'h22, 4'b0001, 1'b0);
        checkOutput("d4_head_new", out_data0, 64'h22);
        applyStimulus(1'b1, 2'd0, 64'h33, 4'b0000, 1'b0);
        checkOutput("d4_count_one_ready", {63'b0, last_ready}, 64'h1);

        // Reset mid-operation discards buffered words, even with push/pop requested
        applyStimulus(1'b1, 2'd1, 64'h44, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd2, 64'h66, 4'b0000, 1'b0);
        applyStimulus(1'b1, 2'd3, rnd64(), 4'b1111, 1'b1);
        checkOutput("d5_out_valid", {60'b0, out_valid}, 64'h0);
        checkOutput("d5_data0", out_data0, 64'h0);
        checkOutput("d5_data1", out_data1, 64'h0);
        checkOutput("d5_data2", out_data2, 64'h0);
        checkOutput("d5_data3", out_data3, 64'h0);
        checkOutput("d5_xfer", {48'b0, xfer_count}, 64'h0);
        for (int d = 0; d < 4; d++) begin
            applyStimulus(1'b0, 2'(d), rnd64(), 4'b0000, 1'b0);
            checkOutput($sformatf("d5_ready_dest%0d", d), {63'b0, last_ready}, 64'h1);
        end

        // 65536 accepted words wrap the transfer counter back to zero
        applyStimulus(1'b0, 2'd0, '0, 4'b0000, 1'b1);
        for (int n = 0; n < 65536; n++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), rnd64(), 4'b1111, 1'b0);
        end
        checkOutput("d6_xfer_wrap", {48'b0, xfer_count}, 64'h0);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd64(),
                          4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0);
        end
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 2'($urandom_range(0, 3)), rnd64(), 4'b1111, 1'b0);
        end
        checkOutput("final_out_valid", {60'b0, out_valid}, 64'h0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
